// File: rtl/test_sequencer.sv
// Multi-test sequencer for RV32i bring-up: for each test, holds the core in
// reset, releases it, then watches the data-memory write bus for a TOHOST
// write or a timeout and records pass/fail/timeout before moving on.
module test_sequencer #(
  parameter int unsigned       NUM_TESTS    = 3,
  parameter int unsigned       RESET_CYCLES = 10,
  parameter int unsigned       TIMEOUT      = 1024,
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR  = ADDR_W'(32'h100),
  localparam int unsigned      IDX_W        = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 core_rst_n,
  output logic [IDX_W-1:0]     test_idx,
  input  logic                 mem_we,
  input  logic [ADDR_W-1:0]    mem_addr,
  input  logic [31:0]          mem_wdata,
  output logic                 busy,
  output logic                 done,
  output logic [NUM_TESTS-1:0] pass_mask,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] timeout_mask,
  output logic [31:0]          fail_code
);

  // One counter serves both the RESET hold and the RUN timeout, so it must
  // be wide enough for whichever limit is larger.
  localparam int unsigned RUN_W = $clog2(TIMEOUT + 1);
  localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned CNT_W = (RUN_W > RST_W) ? RUN_W : RST_W;

  localparam logic [CNT_W-1:0] RESET_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_TESTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_RECORD,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [IDX_W-1:0]       r_idx;
  logic [NUM_TESTS-1:0]   r_pass;
  logic [NUM_TESTS-1:0]   r_fail;
  logic [NUM_TESTS-1:0]   r_timeout;
  logic [31:0]            r_fail_code;

  logic                   w_hit;
  logic                   w_reset_last;
  logic                   w_run_last;
  logic                   w_last_test;
  logic [NUM_TESTS-1:0]   w_sel;

  assign w_hit        = mem_we && (mem_addr == TOHOST_ADDR) && (mem_wdata != 32'd0);
  assign w_reset_last = (r_cnt == RESET_LAST);
  assign w_run_last   = (r_cnt == RUN_LAST);
  assign w_last_test  = (r_idx == LAST_IDX);
  assign w_sel        = NUM_TESTS'(1) << r_idx;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; a hit on the final RUN cycle wins over the timeout
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_state_nxt = S_RESET;
      S_RESET:        if (w_reset_last) w_state_nxt = S_RUN;
      S_RUN:          if (w_hit || w_run_last) w_state_nxt = S_RECORD;
      S_RECORD:       w_state_nxt = w_last_test ? S_DONE : S_RESET;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs: the core only runs while the sequencer is in RUN
  always_comb begin
    core_rst_n = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (r_state)
      S_RESET, S_RECORD: busy = 1'b1;
      S_RUN: begin
        busy       = 1'b1;
        core_rst_n = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: cycle counter, test index and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_timeout   <= '0;
      r_fail_code <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_cnt       <= '0;
            r_idx       <= '0;
            r_pass      <= '0;
            r_fail      <= '0;
            r_timeout   <= '0;
            r_fail_code <= '0;
          end
        end
        S_RESET: r_cnt <= w_reset_last ? '0 : r_cnt + 1'b1;
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_hit) begin
            if (mem_wdata == 32'd1) begin
              r_pass <= r_pass | w_sel;
            end else begin
              r_fail      <= r_fail | w_sel;
              r_fail_code <= mem_wdata;
            end
          end else if (w_run_last) begin
            r_timeout <= r_timeout | w_sel;
          end
        end
        S_RECORD: begin
          r_cnt <= '0;
          if (!w_last_test) r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign test_idx     = r_idx;
  assign pass_mask    = r_pass;
  assign fail_mask    = r_fail;
  assign timeout_mask = r_timeout;
  assign fail_code    = r_fail_code;

endmodule

// File: tb/tb_test_sequencer.sv
// Testbench for test_sequencer: directed scenarios plus randomized test
// outcomes, checked against an expected-result model of the sequence.
module tb_test_sequencer;

  localparam int unsigned NT = 3;
  localparam int unsigned RC = 10;
  localparam int unsigned TO = 1024;
  localparam logic [31:0] TOHOST = 32'h100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        core_rst_n;
  logic [1:0]  test_idx;
  logic        busy;
  logic        done;
  logic [NT-1:0] pass_mask;
  logic [NT-1:0] fail_mask;
  logic [NT-1:0] timeout_mask;
  logic [31:0] fail_code;

  int n_checks = 0;
  int n_errors = 0;

  // Expected results of the sequence currently in flight
  logic [NT-1:0] m_pass = '0;
  logic [NT-1:0] m_fail = '0;
  logic [NT-1:0] m_to   = '0;
  logic [31:0]   m_code = '0;

  test_sequencer #(
    .NUM_TESTS   (NT),
    .RESET_CYCLES(RC),
    .TIMEOUT     (TO),
    .ADDR_W      (32),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .core_rst_n  (core_rst_n),
    .test_idx    (test_idx),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .busy        (busy),
    .done        (done),
    .pass_mask   (pass_mask),
    .fail_mask   (fail_mask),
    .timeout_mask(timeout_mask),
    .fail_code   (fail_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_results(input string tag);
    chk({tag, "_pass"}, 32'(pass_mask), 32'(m_pass));
    chk({tag, "_fail"}, 32'(fail_mask), 32'(m_fail));
    chk({tag, "_tmo"},  32'(timeout_mask), 32'(m_to));
    chk({tag, "_code"}, fail_code, m_code);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_idx"}, 32'(test_idx), 32'd0);
    chk_results(tag);
  endtask

  task automatic bus_quiet();
    start     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
  endtask

  // Random bus traffic; with allow_hit=0 it never forms a valid TOHOST hit
  task automatic noise(input bit allow_hit, input bit allow_start);
    start = allow_start && ($urandom_range(7) == 0);
    if (allow_hit) begin
      mem_we    = 1'($urandom_range(1));
      mem_addr  = ($urandom_range(1) == 1) ? TOHOST : $urandom;
      mem_wdata = $urandom_range(3);
    end else begin
      case ($urandom_range(3))
        0: begin mem_we = 1'b0; mem_addr = TOHOST;      mem_wdata = $urandom | 32'd1; end
        1: begin mem_we = 1'b1; mem_addr = TOHOST + 4;  mem_wdata = 32'd1; end
        2: begin mem_we = 1'b1; mem_addr = TOHOST;      mem_wdata = 32'd0; end
        default: begin
          mem_we    = 1'b1;
          mem_addr  = $urandom;
          if (mem_addr == TOHOST) mem_addr = mem_addr ^ 32'd1;
          mem_wdata = $urandom | 32'd1;
        end
      endcase
    end
  endtask

  // Called on a negedge with the sequencer in IDLE or DONE
  task automatic start_seq();
    bus_quiet();
    start = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    m_pass = '0;
    m_fail = '0;
    m_to   = '0;
    m_code = '0;
  endtask

  // Entered on the negedge of the first RESET cycle of test idx.
  // kind: 0 pass, 1 fail with code, 2 timeout. hitc: 1-based RUN cycle of the hit.
  task automatic do_test(input int idx, input int kind, input int hitc, input logic [31:0] code);
    logic [NT-1:0] sel;
    sel = NT'(1) << idx;
    for (int c = 1; c <= int'(RC); c++) begin
      chk("reset_core_rst_n", 32'(core_rst_n), 32'd0);
      chk("reset_busy", 32'(busy), 32'd1);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_idx", 32'(test_idx), 32'(idx));
      if (c == 1) chk_results("reset");
      noise(1'b1, 1'b1);
      @(negedge clk);
    end
    for (int r = 1; r <= int'(TO); r++) begin
      chk("run_core_rst_n", 32'(core_rst_n), 32'd1);
      chk("run_busy", 32'(busy), 32'd1);
      if (kind != 2 && r == hitc) begin
        start     = ($urandom_range(1) == 1);
        mem_we    = 1'b1;
        mem_addr  = TOHOST;
        mem_wdata = code;
        @(negedge clk);
        break;
      end
      noise(1'b0, 1'b1);
      if (hitc > 6 && r == 5) begin mem_we = 1'b1; mem_addr = TOHOST + 4; mem_wdata = 32'd1; end
      if (hitc > 6 && r == 6) begin mem_we = 1'b1; mem_addr = TOHOST;     mem_wdata = 32'd0; end
      @(negedge clk);
    end
    case (kind)
      0: m_pass = m_pass | sel;
      1: begin m_fail = m_fail | sel; m_code = code; end
      default: m_to = m_to | sel;
    endcase
    chk("record_core_rst_n", 32'(core_rst_n), 32'd0);
    chk("record_busy", 32'(busy), 32'd1);
    chk("record_idx", 32'(test_idx), 32'(idx));
    chk_results("record");
    noise(1'b1, 1'b1);
    @(negedge clk);
    bus_quiet();
    if (idx == int'(NT) - 1) begin
      chk("done_done", 32'(done), 32'd1);
      chk("done_busy", 32'(busy), 32'd0);
      chk("done_core_rst_n", 32'(core_rst_n), 32'd0);
      chk("done_idx", 32'(test_idx), 32'(idx));
      chk_results("done");
    end
  endtask

  task automatic rand_test(input int idx);
    int          kind;
    int          hitc;
    logic [31:0] code;
    kind = int'($urandom_range(2));
    hitc = int'($urandom_range(TO, 1));
    code = $urandom;
    if (code < 32'd2) code = 32'd7;
    if (kind == 0) code = 32'd1;
    do_test(idx, kind, hitc, code);
  endtask

  task automatic done_hold();
    repeat (4) begin
      noise(1'b1, 1'b0);
      @(negedge clk);
      chk("hold_done", 32'(done), 32'd1);
      chk("hold_busy", 32'(busy), 32'd0);
      chk_results("hold");
    end
    bus_quiet();
  endtask

  initial begin
    rst = 1'b1;
    bus_quiet();
    repeat (3) @(negedge clk);
    chk_idle("por");
    rst = 1'b0;

    // Bus traffic in IDLE must not start anything
    repeat (5) begin
      noise(1'b1, 1'b0);
      @(negedge clk);
      chk_idle("idle");
    end

    // Directed: pass at RUN cycle 20, fail code 7, timeout
    start_seq();
    do_test(0, 0, 20, 32'd1);
    do_test(1, 1, int'($urandom_range(80, 30)), 32'd7);
    do_test(2, 2, int'(TO), 32'd0);
    done_hold();

    // Restart from DONE; pass exactly on the last RUN cycle
    start_seq();
    do_test(0, 0, int'(TO), 32'd1);
    rand_test(1);
    rand_test(2);
    done_hold();

    // Fully random sequence
    start_seq();
    for (int i = 0; i < int'(NT); i++) rand_test(i);
    done_hold();

    // Synchronous reset while test 1 is running
    start_seq();
    rand_test(0);
    repeat (RC) begin
      noise(1'b1, 1'b1);
      @(negedge clk);
    end
    repeat (7) begin
      chk("pre_rst_core_rst_n", 32'(core_rst_n), 32'd1);
      noise(1'b0, 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    m_pass = '0;
    m_fail = '0;
    m_to   = '0;
    m_code = '0;
    @(negedge clk);
    chk_idle("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      noise(1'b1, 1'b0);
      @(negedge clk);
      chk_idle("post_rst");
    end

    // Sequence from IDLE after the reset
    start_seq();
    for (int i = 0; i < int'(NT); i++) rand_test(i);
    done_hold();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
